// File: rtl/csr_regblock.sv
// CSR register block behind the generic bus port of the APB4 bridge.
// Holds CTRL/STATUS/SCRATCH/ID/COUNT and answers each accepted request
// with a one-cycle registered ack carrying read data or an error flag.
module csr_regblock #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STATUS_WIDTH = 8,
  parameter logic [31:0] ID_VALUE     = 32'hC5B0_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_req,
  input  logic                      bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]     bus_addr,
  input  logic [DATA_WIDTH-1:0]     bus_wr_data,
  input  logic [DATA_WIDTH/8-1:0]   bus_wr_biten,
  output logic                      bus_req_stall_wr,
  output logic                      bus_req_stall_rd,
  output logic                      bus_rd_ack,
  output logic                      bus_rd_err,
  output logic [DATA_WIDTH-1:0]     bus_rd_data,
  output logic                      bus_wr_ack,
  output logic                      bus_wr_err,
  output logic [7:0]                ctrl_o,
  input  logic [STATUS_WIDTH-1:0]   hw_status_set,
  input  logic                      hw_event,
  output logic                      irq_o
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [IDX_WIDTH-1:0] IDX_CTRL    = IDX_WIDTH'(0);
  localparam logic [IDX_WIDTH-1:0] IDX_STATUS  = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_SCRATCH = IDX_WIDTH'(2);
  localparam logic [IDX_WIDTH-1:0] IDX_ID      = IDX_WIDTH'(3);
  localparam logic [IDX_WIDTH-1:0] IDX_COUNT   = IDX_WIDTH'(4);

  logic [0:0]              state_q;
  logic [0:0]              state_d;

  logic [15:0]             ctrl_q;
  logic [15:0]             ctrl_d;
  logic [STATUS_WIDTH-1:0] status_q;
  logic [STATUS_WIDTH-1:0] status_d;
  logic [DATA_WIDTH-1:0]   scratch_q;
  logic [DATA_WIDTH-1:0]   scratch_d;
  logic [DATA_WIDTH-1:0]   count_q;
  logic [DATA_WIDTH-1:0]   count_d;

  logic                    accept_c;
  logic                    acc_err_c;
  logic                    wr_ok_c;
  logic                    count_clr_c;
  logic [IDX_WIDTH-1:0]    idx_c;
  logic [DATA_WIDTH-1:0]   be_mask_c;
  logic [DATA_WIDTH-1:0]   rd_value_c;
  logic [STATUS_WIDTH-1:0] w1c_c;

  logic                    rd_ack_d;
  logic                    wr_ack_d;
  logic                    rd_err_d;
  logic                    wr_err_d;
  logic [DATA_WIDTH-1:0]   rd_data_d;
  logic                    irq_d;
  logic                    irq_q;

  assign idx_c    = bus_addr[ADDR_WIDTH-1:2];
  assign accept_c = bus_req & (state_q == ST_IDLE);

  // Expand per-byte enables into a bit mask
  always_comb begin
    be_mask_c = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      be_mask_c[b*8 +: 8] = {8{bus_wr_biten[b]}};
    end
  end

  // Address decode: read mux and access error detection
  always_comb begin
    acc_err_c  = (bus_addr[1:0] != 2'b00);
    rd_value_c = '0;
    case (idx_c)
      IDX_CTRL:    rd_value_c = DATA_WIDTH'(ctrl_q);
      IDX_STATUS:  rd_value_c = DATA_WIDTH'(status_q);
      IDX_SCRATCH: rd_value_c = scratch_q;
      IDX_ID: begin
        rd_value_c = DATA_WIDTH'(ID_VALUE);
        if (bus_req_is_wr) acc_err_c = 1'b1;
      end
      IDX_COUNT: begin
        rd_value_c = count_q;
        if (bus_req_is_wr) acc_err_c = 1'b1;
      end
      default:     acc_err_c = 1'b1;
    endcase
  end

  // CSR next values: bus writes merged with hardware set/event inputs
  always_comb begin
    ctrl_d      = ctrl_q;
    scratch_d   = scratch_q;
    w1c_c       = '0;
    count_clr_c = 1'b0;
    wr_ok_c     = accept_c & bus_req_is_wr & ~acc_err_c;
    if (wr_ok_c) begin
      case (idx_c)
        IDX_CTRL: begin
          ctrl_d      = (ctrl_q & ~be_mask_c[15:0]) | (bus_wr_data[15:0] & be_mask_c[15:0]);
          count_clr_c = bus_wr_data[31] & be_mask_c[31];
        end
        IDX_STATUS:  w1c_c = bus_wr_data[STATUS_WIDTH-1:0] & be_mask_c[STATUS_WIDTH-1:0];
        IDX_SCRATCH: scratch_d = (scratch_q & ~be_mask_c) | (bus_wr_data & be_mask_c);
        default:     ;
      endcase
    end
    // Hardware set is applied after the clear so a same-cycle set wins
    status_d = (status_q & ~w1c_c) | hw_status_set;
    if (count_clr_c) begin
      count_d = '0;
    end else if (hw_event && (count_q != {DATA_WIDTH{1'b1}})) begin
      count_d = count_q + DATA_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FSM next state and registered response values
  always_comb begin
    state_d   = state_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    wr_err_d  = 1'b0;
    rd_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          state_d   = ST_RESP;
          rd_ack_d  = ~bus_req_is_wr;
          wr_ack_d  = bus_req_is_wr;
          rd_err_d  = ~bus_req_is_wr & acc_err_c;
          wr_err_d  = bus_req_is_wr & acc_err_c;
          if (!bus_req_is_wr && !acc_err_c) rd_data_d = rd_value_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = |(status_q & ctrl_q[8 +: STATUS_WIDTH]);
  end

  // State, CSR and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      status_q    <= '0;
      scratch_q   <= '0;
      count_q     <= '0;
      bus_rd_ack  <= 1'b0;
      bus_wr_ack  <= 1'b0;
      bus_rd_err  <= 1'b0;
      bus_wr_err  <= 1'b0;
      bus_rd_data <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      status_q    <= status_d;
      scratch_q   <= scratch_d;
      count_q     <= count_d;
      bus_rd_ack  <= rd_ack_d;
      bus_wr_ack  <= wr_ack_d;
      bus_rd_err  <= rd_err_d;
      bus_wr_err  <= wr_err_d;
      bus_rd_data <= rd_data_d;
      irq_q       <= irq_d;
    end
  end

  assign bus_req_stall_wr = (state_q == ST_RESP);
  assign bus_req_stall_rd = (state_q == ST_RESP);
  assign ctrl_o           = ctrl_q[7:0];
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_csr_regblock.sv
// Scoreboard bench for csr_regblock: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever an ack is presented.
module tb_csr_regblock;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_req;
  logic          bus_req_is_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [3:0]    bus_wr_biten;
  logic          bus_req_stall_wr;
  logic          bus_req_stall_rd;
  logic          bus_rd_ack;
  logic          bus_rd_err;
  logic [DW-1:0] bus_rd_data;
  logic          bus_wr_ack;
  logic          bus_wr_err;
  logic [7:0]    ctrl_o;
  logic [SW-1:0] hw_status_set;
  logic          hw_event;
  logic          irq_o;

  typedef struct {
    logic          is_wr;
    logic          err;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;

  csr_regblock #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STATUS_WIDTH(SW),
    .ID_VALUE    (32'hC5B0_0001)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus_req         (bus_req),
    .bus_req_is_wr   (bus_req_is_wr),
    .bus_addr        (bus_addr),
    .bus_wr_data     (bus_wr_data),
    .bus_wr_biten    (bus_wr_biten),
    .bus_req_stall_wr(bus_req_stall_wr),
    .bus_req_stall_rd(bus_req_stall_rd),
    .bus_rd_ack      (bus_rd_ack),
    .bus_rd_err      (bus_rd_err),
    .bus_rd_data     (bus_rd_data),
    .bus_wr_ack      (bus_wr_ack),
    .bus_wr_err      (bus_wr_err),
    .ctrl_o          (ctrl_o),
    .hw_status_set   (hw_status_set),
    .hw_event        (hw_event),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus_rd_ack || bus_wr_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: rd_ack=%b wr_ack=%b with nothing outstanding (cycle %0d)",
                   bus_rd_ack, bus_wr_ack, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_kind", 32'({bus_rd_ack, bus_wr_ack}), e.is_wr ? 32'd1 : 32'd2);
          chk("ack_latency", 32'(cyc), 32'(e.due));
          chk("resp_err", 32'({bus_rd_err, bus_wr_err}),
              e.is_wr ? 32'({1'b0, e.err}) : 32'({e.err, 1'b0}));
          chk("rd_data", bus_rd_data, e.data);
        end
      end else begin
        chk("idle_resp", bus_rd_data | 32'({bus_rd_err, bus_wr_err}), 32'd0);
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [3:0] be, input logic exp_err, input logic [DW-1:0] exp_data);
    exp_t e;
    e.is_wr = wr;
    e.err   = exp_err;
    e.data  = (wr || exp_err) ? '0 : exp_data;
    e.due   = cyc + 1;
    exp_q.push_back(e);
    bus_req       = 1'b1;
    bus_req_is_wr = wr;
    bus_addr      = addr;
    bus_wr_data   = wdata;
    bus_wr_biten  = be;
    @(negedge clk);
    bus_req       = 1'b0;
    hw_event      = 1'b0;
    hw_status_set = '0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic exp_err, input logic [DW-1:0] exp_data);
    issue(1'b0, addr, '0, 4'hF, exp_err, exp_data);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] be,
                    input logic exp_err);
    issue(1'b1, addr, data, be, exp_err, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus_req       = 1'b0;
    bus_req_is_wr = 1'b0;
    bus_addr      = '0;
    bus_wr_data   = '0;
    bus_wr_biten  = '0;
    hw_status_set = '0;
    hw_event      = 1'b0;

    // Reset state
    idle(2);
    chk("reset_resp", 32'({bus_rd_ack, bus_wr_ack, bus_rd_err, bus_wr_err}), 32'd0);
    chk("reset_rd_data", bus_rd_data, 32'd0);
    chk("reset_stall", 32'({bus_req_stall_wr, bus_req_stall_rd}), 32'd0);
    chk("reset_ctrl_o", 32'(ctrl_o), 32'd0);
    chk("reset_irq", 32'(irq_o), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    rd(5'h0C, 1'b0, 32'hC5B0_0001);

    // Byte enables on SCRATCH
    wr(5'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(5'h08, 32'h1234_5678, 4'b0101, 1'b0);
    rd(5'h08, 1'b0, 32'hFF34_FF78);

    // STATUS set vs W1C, then irq
    hw_status_set = 8'h03;
    @(negedge clk);
    hw_status_set = 8'h01;
    wr(5'h04, 32'h0000_0001, 4'hF, 1'b0);
    rd(5'h04, 1'b0, 32'h0000_0003);
    wr(5'h04, 32'h0000_0003, 4'hF, 1'b0);
    rd(5'h04, 1'b0, 32'h0000_0000);
    chk("irq_none", 32'(irq_o), 32'd0);
    hw_status_set = 8'h02;
    @(negedge clk);
    hw_status_set = '0;
    wr(5'h00, 32'h0000_02A5, 4'hF, 1'b0);
    idle(1);
    chk("irq_set", 32'(irq_o), 32'd1);
    chk("ctrl_o", 32'(ctrl_o), 32'h0000_00A5);
    rd(5'h00, 1'b0, 32'h0000_02A5);
    wr(5'h04, 32'h0000_0002, 4'hF, 1'b0);
    idle(1);
    chk("irq_cleared", 32'(irq_o), 32'd0);

    // COUNT increment, clear-with-event, saturation
    hw_event = 1'b1;
    idle(5);
    hw_event = 1'b0;
    rd(5'h10, 1'b0, 32'd5);
    rd(5'h10, 1'b0, 32'd5);
    hw_event = 1'b1;
    wr(5'h00, 32'h8000_02A5, 4'hF, 1'b0);
    rd(5'h10, 1'b0, 32'd0);
    rd(5'h00, 1'b0, 32'h0000_02A5);
    force dut.count_q = 32'hFFFF_FFFF;
    hw_event = 1'b1;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    hw_event = 1'b0;
    rd(5'h10, 1'b0, 32'hFFFF_FFFF);

    // Error cases
    rd(5'h14, 1'b1, 32'd0);
    wr(5'h0E, 32'h0000_0000, 4'hF, 1'b1);
    wr(5'h0C, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd(5'h0C, 1'b0, 32'hC5B0_0001);
    wr(5'h10, 32'h0000_0000, 4'hF, 1'b1);
    rd(5'h10, 1'b0, 32'hFFFF_FFFF);
    wr(5'h09, 32'h0000_0000, 4'hF, 1'b1);
    rd(5'h08, 1'b0, 32'hFF34_FF78);
    rd(5'h1C, 1'b1, 32'd0);

    // Back-to-back: second request is ignored, third is served
    begin
      exp_t e;
      e.is_wr = 1'b0; e.err = 1'b0; e.data = 32'hC5B0_0001; e.due = cyc + 1;
      exp_q.push_back(e);
      bus_req = 1'b1; bus_req_is_wr = 1'b0; bus_addr = 5'h0C; bus_wr_biten = 4'hF;
      @(negedge clk);
      chk("b2b_stall_resp", 32'({bus_req_stall_wr, bus_req_stall_rd}), 32'd3);
      bus_req = 1'b1; bus_req_is_wr = 1'b1; bus_addr = 5'h08; bus_wr_data = 32'h0;
      @(negedge clk);
      chk("b2b_stall_idle", 32'({bus_req_stall_wr, bus_req_stall_rd}), 32'd0);
      e.is_wr = 1'b0; e.err = 1'b0; e.data = 32'hFF34_FF78; e.due = cyc + 1;
      exp_q.push_back(e);
      bus_req = 1'b1; bus_req_is_wr = 1'b0; bus_addr = 5'h08;
      @(negedge clk);
      bus_req = 1'b0;
      @(negedge clk);
    end

    // Reset while a response is on the bus
    begin
      exp_t e;
      e.is_wr = 1'b0; e.err = 1'b0; e.data = 32'hFF34_FF78; e.due = cyc + 1;
      exp_q.push_back(e);
      bus_req = 1'b1; bus_req_is_wr = 1'b0; bus_addr = 5'h08;
      @(negedge clk);
      bus_req = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_resp", 32'({bus_rd_ack, bus_wr_ack, bus_req_stall_wr, bus_req_stall_rd}), 32'd0);
      chk("rst_ctrl_o", 32'(ctrl_o), 32'd0);
      @(negedge clk);
    end
    rd(5'h08, 1'b0, 32'd0);
    rd(5'h00, 1'b0, 32'd0);
    rd(5'h10, 1'b0, 32'd0);

    idle(5);
    chk("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
